// File: rtl/sram_pkg.sv
// ---------------------------------------------------------------------------
// sram_pkg
// Shared constants and types for the banked SRAM array built from
// sky130_sram_2kbyte_1rw1r_32x512_8 macros.
//   MACRO_AW / MACRO_DEPTH : row address width and row count of one macro
//   MACRO_DW / MACRO_MW    : data width and write-mask width of one macro
//   state_t                : array controller state (zero-fill or running)
// ---------------------------------------------------------------------------
package sram_pkg;

    localparam int MACRO_AW    = 9;
    localparam int MACRO_DEPTH = 512;
    localparam int MACRO_DW    = 32;
    localparam int MACRO_MW    = 4;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/sram_banked_array_if.sv
// ---------------------------------------------------------------------------
// sram_banked_array_if
// Single-port RW access bus of the banked SRAM array.
//   RW0_addr/en/wmode/wmask/wdata : request, driven by the master
//   RW0_rdata/rvalid/ready        : response and flow control, driven by the
//                                   array (slave)
// ---------------------------------------------------------------------------
interface sram_banked_array_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 11
);
    logic [ADDR_W-1:0]   RW0_addr;
    logic                RW0_en;
    logic                RW0_wmode;
    logic [DATA_W/8-1:0] RW0_wmask;
    logic [DATA_W-1:0]   RW0_wdata;
    logic [DATA_W-1:0]   RW0_rdata;
    logic                RW0_rvalid;
    logic                RW0_ready;

    modport master (
        output RW0_addr, RW0_en, RW0_wmode, RW0_wmask, RW0_wdata,
        input  RW0_rdata, RW0_rvalid, RW0_ready
    );

    modport slave (
        input  RW0_addr, RW0_en, RW0_wmode, RW0_wmask, RW0_wdata,
        output RW0_rdata, RW0_rvalid, RW0_ready
    );
endinterface

// File: rtl/sky130_sram_2kbyte_1rw1r_32x512_8.sv
// ---------------------------------------------------------------------------
// sky130_sram_2kbyte_1rw1r_32x512_8
// Behavioural stand-in for the 32x512 1RW+1R hard macro, used when the real
// macro view is not linked. Active-low chip select and write enable;
// port 0 reads and writes at the clock edge, port 1 is read-only.
//   clk0, csb0, web0, wmask0, addr0, din0, dout0 : RW port
//   clk1, csb1, addr1, dout1                     : R port
// Read data is registered and holds its value on writes and idle cycles.
// ---------------------------------------------------------------------------
module sky130_sram_2kbyte_1rw1r_32x512_8 #(
    parameter int VERBOSE = 1
) (
    input  logic        clk0,
    input  logic        csb0,
    input  logic        web0,
    input  logic [3:0]  wmask0,
    input  logic [8:0]  addr0,
    input  logic [31:0] din0,
    output logic [31:0] dout0,
    input  logic        clk1,
    input  logic        csb1,
    input  logic [8:0]  addr1,
    output logic [31:0] dout1
);
    // The real macro prints access traces when VERBOSE is set; the model
    // accepts the parameter so instances stay drop-in compatible.
    localparam bit verbose_unused = (VERBOSE != 0);

    logic [31:0] mem [512];

    // Port 0: byte-masked write, or registered read.
    always_ff @(posedge clk0) begin
        if (!csb0) begin
            if (!web0) begin
                for (int i = 0; i < 4; i++) begin
                    if (wmask0[i]) begin
                        mem[addr0][i*8 +: 8] <= din0[i*8 +: 8];
                    end
                end
            end else begin
                dout0 <= mem[addr0];
            end
        end
    end

    // Port 1: registered read only.
    always_ff @(posedge clk1) begin
        if (!csb1) begin
            dout1 <= mem[addr1];
        end
    end
endmodule

// File: rtl/sram_bank.sv
// ---------------------------------------------------------------------------
// sram_bank
// One bank of the array: LANES macros side by side sharing chip select,
// write enable and row address; each lane owns a 32-bit slice of the data
// and a 4-bit slice of the byte mask. Port 1 of every macro is tied off.
//   clk        : macro clock
//   csb, web   : active-low select / write enable for all lanes
//   addr       : macro row
//   din, wmask : full-width write data and byte mask
//   dout       : full-width registered read data
// ---------------------------------------------------------------------------
module sram_bank
    import sram_pkg::*;
#(
    parameter int LANES   = 2,
    parameter int VERBOSE = 0
) (
    input  logic                         clk,
    input  logic                         csb,
    input  logic                         web,
    input  logic [MACRO_AW-1:0]          addr,
    input  logic [LANES*MACRO_DW-1:0]    din,
    input  logic [LANES*MACRO_MW-1:0]    wmask,
    output logic [LANES*MACRO_DW-1:0]    dout
);
    logic [MACRO_DW-1:0] dout1_unused [LANES];

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        sky130_sram_2kbyte_1rw1r_32x512_8 #(
            .VERBOSE (VERBOSE)
        ) u_macro (
            .clk0   (clk),
            .csb0   (csb),
            .web0   (web),
            .wmask0 (wmask[l*MACRO_MW +: MACRO_MW]),
            .addr0  (addr),
            .din0   (din[l*MACRO_DW +: MACRO_DW]),
            .dout0  (dout[l*MACRO_DW +: MACRO_DW]),
            .clk1   (clk),
            .csb1   (1'b1),
            .addr1  ('0),
            .dout1  (dout1_unused[l])
        );
    end
endmodule

// File: rtl/sram_banked_array.sv
// ---------------------------------------------------------------------------
// sram_banked_array
// Single-port RW memory of DATA_W x 2^ADDR_W built from NBANK banks of
// LANES 32x512 macros. Adds a one-cycle registered read-valid, a read-data
// hold register, a ready flag and (optionally) a post-reset zero fill.
//   RW0_clk : clock for all logic and both macro ports
//   reset   : asynchronous, active-high
//   bus     : sram_banked_array_if slave (addr/en/wmode/wmask/wdata in,
//             rdata/rvalid/ready out)
// Build option: define SRAM_INIT_EN to zero-fill all 512 rows of every bank
// after reset, with ready held low until the fill finishes.
// ---------------------------------------------------------------------------
module sram_banked_array
    import sram_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int ADDR_W  = 11,
    parameter int VERBOSE = 0
) (
    input  logic               RW0_clk,
    input  logic               reset,
    sram_banked_array_if.slave bus
);
    localparam int NBANK  = 1 << (ADDR_W - MACRO_AW);
    localparam int LANES  = DATA_W / MACRO_DW;
    localparam int MASK_W = DATA_W / 8;
    localparam int BANK_W = (ADDR_W > MACRO_AW) ? (ADDR_W - MACRO_AW) : 1;

    state_t              state;
    logic                ready_q;
    logic                rvalid_q;
    logic [NBANK-1:0]    sel;
    logic [NBANK-1:0]    rd_sel;
    logic [DATA_W-1:0]   bank_dout [NBANK];
    logic [DATA_W-1:0]   rd_mux;
    logic [DATA_W-1:0]   rdata_hold;
    logic                acc;
    logic                rd_acc;

    logic                mac_fill;
    logic                mac_web;
    logic [MACRO_AW-1:0] mac_addr;
    logic [DATA_W-1:0]   mac_din;
    logic [MASK_W-1:0]   mac_wmask;

    assign acc    = bus.RW0_en & ready_q;
    assign rd_acc = acc & ~bus.RW0_wmode;

    // Upper address bits pick exactly one bank; a single-bank build has
    // no bank field at all.
    if (NBANK == 1) begin : g_one_bank
        assign sel = acc;
    end else begin : g_multi_bank
        for (genvar b = 0; b < NBANK; b++) begin : g_sel
            assign sel[b] = acc && (bus.RW0_addr[ADDR_W-1:MACRO_AW] == BANK_W'(b));
        end
    end

`ifdef SRAM_INIT_EN
    logic [MACRO_AW-1:0] init_row;

    // While filling, every bank writes zero to the row counter and the
    // user request path is muxed off.
    assign mac_fill  = (state == ST_INIT);
    assign mac_web   = mac_fill ? 1'b0 : ~bus.RW0_wmode;
    assign mac_addr  = mac_fill ? init_row : bus.RW0_addr[MACRO_AW-1:0];
    assign mac_din   = mac_fill ? '0 : bus.RW0_wdata;
    assign mac_wmask = mac_fill ? '1 : bus.RW0_wmask;

    // Fill sequencer: one row per cycle, ready rises in the cycle after
    // the last row has been written.
    always_ff @(posedge RW0_clk or posedge reset) begin
        if (reset) begin
            state    <= ST_INIT;
            init_row <= '0;
            ready_q  <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    init_row <= init_row + 1'b1;
                    if (init_row == MACRO_AW'(MACRO_DEPTH - 1)) begin
                        state   <= ST_RUN;
                        ready_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    ready_q <= 1'b1;
                end
            endcase
        end
    end
`else
    assign mac_fill  = 1'b0;
    assign mac_web   = ~bus.RW0_wmode;
    assign mac_addr  = bus.RW0_addr[MACRO_AW-1:0];
    assign mac_din   = bus.RW0_wdata;
    assign mac_wmask = bus.RW0_wmask;

    // Without the fill the array is usable from the first edge after
    // reset release.
    always_ff @(posedge RW0_clk or posedge reset) begin
        if (reset) begin
            state   <= ST_RUN;
            ready_q <= 1'b0;
        end else begin
            ready_q <= (state == ST_RUN);
        end
    end
`endif

    for (genvar b = 0; b < NBANK; b++) begin : g_bank
        sram_bank #(
            .LANES   (LANES),
            .VERBOSE (VERBOSE)
        ) u_bank (
            .clk   (RW0_clk),
            .csb   (~(sel[b] | mac_fill)),
            .web   (mac_web),
            .addr  (mac_addr),
            .din   (mac_din),
            .wmask (mac_wmask),
            .dout  (bank_dout[b])
        );
    end

    // Only the bank that served the previous read contributes to the
    // read mux; rd_sel is all-zero outside read-response cycles.
    always_comb begin
        rd_mux = '0;
        for (int b = 0; b < NBANK; b++) begin
            if (rd_sel[b]) begin
                rd_mux = rd_mux | bank_dout[b];
            end
        end
    end

    // Read tracking: remember which bank was read so its dout is steered
    // out next cycle, and capture that data so later macro dout changes
    // never reach the output.
    always_ff @(posedge RW0_clk or posedge reset) begin
        if (reset) begin
            rvalid_q   <= 1'b0;
            rd_sel     <= '0;
            rdata_hold <= '0;
        end else begin
            rvalid_q <= rd_acc;
            rd_sel   <= rd_acc ? sel : '0;
            if (rvalid_q) begin
                rdata_hold <= rd_mux;
            end
        end
    end

    assign bus.RW0_rdata  = rvalid_q ? rd_mux : rdata_hold;
    assign bus.RW0_rvalid = rvalid_q;
    assign bus.RW0_ready  = ready_q;
endmodule
